// File: rtl/dac_spi_frame_writer.sv
// Signed samples -> straight-binary 32-bit DAC command frames on 3-wire SPI; frame starts the cycle after accept.
// Latency 1 + 64*CLK_DIV + GAP_CYC per frame; ready only in IDLE (no buffering), so the source stalls for each frame.
module dac_spi_frame_writer #(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 4,
    parameter int CLK_DIV     = 4,
    parameter int GAP_CYC     = 2,
    parameter int UPDATE_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ast_sink_data,
    input  logic [3:0]        ast_sink_channel,
    input  logic              ast_sink_endofpacket,
    input  logic              ast_sink_valid,
    output logic              ast_sink_ready,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              frame_done,
    output logic              chan_err
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [3:0]       CMD       = (UPDATE_MODE != 0) ? 4'b0000 : 4'b0011;
    localparam logic [31:0]      UPD_FRAME = {4'h0, 4'b0001, 4'hF, 16'h0000, 4'h0};

    typedef enum logic [2:0] {IDLE, SHIFT, GAP, UPD_SHIFT, GAP2} state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [31:0]       frame_q;
    logic              pending;
    logic              accept, bad_ch, shifting, in_gap, bit_end, last_tick, gap_done;
    logic [DATA_W-1:0] sbi;
    logic [15:0]       field16;

    assign ast_sink_ready = (state == IDLE) && !reset;
    assign accept         = ast_sink_valid && ast_sink_ready;
    assign bad_ch         = {1'b0, ast_sink_channel} >= 5'(NUM_CH);
    assign shifting       = (state == SHIFT) || (state == UPD_SHIFT);
    assign in_gap         = (state == GAP) || (state == GAP2);
    assign bit_end        = (div_cnt == DIV_LAST);
    assign last_tick      = bit_end && (bit_idx == 5'd0);
    assign gap_done       = (gap_cnt == GAP_LAST);

    // Flipping the sign bit is the same as adding 2^(DATA_W-1)
    assign sbi     = {~ast_sink_data[DATA_W-1], ast_sink_data[DATA_W-2:0]};
    assign field16 = 16'(sbi) << (16 - DATA_W);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (accept && !bad_ch) state_nx = SHIFT;
            SHIFT:     if (last_tick)         state_nx = GAP;
            GAP:       if (gap_done)          state_nx = pending ? UPD_SHIFT : IDLE;
            UPD_SHIFT: if (last_tick)         state_nx = GAP2;
            GAP2:      if (gap_done)          state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_idx    <= 5'd31;
            gap_cnt    <= '0;
            frame_q    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            chan_err   <= 1'b0;
        end else begin
            frame_done <= shifting && last_tick;
            chan_err   <= accept && bad_ch;

            if (shifting) begin
                if (bit_end) begin
                    div_cnt <= '0;
                    bit_idx <= bit_idx - 5'd1;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                bit_idx <= 5'd31;
            end

            if (in_gap && !gap_done) gap_cnt <= gap_cnt + 1'b1;
            else                     gap_cnt <= '0;

            // The update-all frame reuses the shifter once the data frame's gap ends
            if (accept && !bad_ch) begin
                frame_q <= {4'h0, CMD, ast_sink_channel, field16, 4'h0};
                pending <= (UPDATE_MODE != 0) && ast_sink_endofpacket;
            end else if ((state == GAP) && gap_done && pending) begin
                frame_q <= UPD_FRAME;
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        dac_cs_n = 1'b1;
        dac_sclk = 1'b1;
        dac_mosi = 1'b0;
        if (shifting) begin
            dac_cs_n = 1'b0;
            dac_sclk = (div_cnt < DIV_HALF);
            dac_mosi = frame_q[bit_idx];
        end
    end

endmodule

// File: tb/tb_dac_spi_frame_writer.sv
// Two DUTs (immediate-update CLK_DIV=1, deferred-update CLK_DIV=4) against a frame-level model and SPI decoder.
module tb_dac_spi_frame_writer;

    typedef struct {
        int          inst;
        logic [31:0] frame;
        int          start;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [11:0] data [2];
    logic [3:0]  ch [2];
    logic [1:0]  eop;
    logic [1:0]  valid;
    wire  [1:0]  ready, cs_n, sclk, mosi, frame_done, chan_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t expq[$];
    exp_t errq[$];
    bit   [1:0] abort_flag = 2'b00;
    bit   [1:0] prev_hold = 2'b00;
    int   last_acc [2];
    int   want_gap [2];

    dac_spi_frame_writer #(.DATA_W(12), .NUM_CH(4), .CLK_DIV(1), .GAP_CYC(2), .UPDATE_MODE(0)) u0 (
        .clk(clk), .reset(reset), .ast_sink_data(data[0]), .ast_sink_channel(ch[0]),
        .ast_sink_endofpacket(eop[0]), .ast_sink_valid(valid[0]), .ast_sink_ready(ready[0]),
        .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]),
        .frame_done(frame_done[0]), .chan_err(chan_err[0]));

    dac_spi_frame_writer #(.DATA_W(12), .NUM_CH(4), .CLK_DIV(4), .GAP_CYC(2), .UPDATE_MODE(1)) u1 (
        .clk(clk), .reset(reset), .ast_sink_data(data[1]), .ast_sink_channel(ch[1]),
        .ast_sink_endofpacket(eop[1]), .ast_sink_valid(valid[1]), .ast_sink_ready(ready[1]),
        .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]),
        .frame_done(frame_done[1]), .chan_err(chan_err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cdiv(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int frame_len(input int i);
        return 64 * cdiv(i) + 2;
    endfunction

    // Frame from the datasheet layout: cmd at 27:24, addr at 23:20, 16-bit field at 19:4
    function automatic logic [31:0] frame_of(input int i, input logic [11:0] d, input int c);
        int sv, sbi, cmd;
        sv  = (d >= 12'd2048) ? int'(d) - 4096 : int'(d);
        sbi = sv + 2048;
        cmd = (i == 1) ? 0 : 3;
        return 32'(cmd * (1 << 24) + c * (1 << 20) + sbi * 16 * 16);
    endfunction

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the following negedge once the sample is taken.
    task automatic send(input int i, input logic [11:0] d, input int c, input bit e, input int idle);
        int n = 0;
        int acc, want;
        data[i]  = d;
        ch[i]    = 4'(c);
        eop[i]   = e;
        valid[i] = 1'b1;
        while (!ready[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready[i]) begin
            chk(1'b0, "accept_timeout", n, 3000);
            valid[i] = 1'b0;
            prev_hold[i] = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (prev_hold[i]) chk(acc - last_acc[i] == want_gap[i], "accept_spacing", acc - last_acc[i], want_gap[i]);
        if (c >= 4) begin
            errq.push_back('{i, 32'h0, acc});
            want = 1;
        end else begin
            expq.push_back('{i, frame_of(i, d, c), acc});
            want = 1 + frame_len(i);
            if (i == 1 && e) begin
                expq.push_back('{i, 32'h01F0_0000, acc + frame_len(i)});
                want += frame_len(i);
            end
        end
        last_acc[i] = acc;
        want_gap[i] = want;
        @(negedge clk);
        if (idle > 0) begin
            valid[i] = 1'b0;
            prev_hold[i] = 1'b0;
            repeat (idle) @(negedge clk);
        end else begin
            prev_hold[i] = 1'b1;
        end
    endtask

    task automatic monitor(input int i);
        logic [31:0] sh = 0;
        int nb = 0, st = 0, unstable = 0, k;
        bit pcs = 1'b1, psclk = 1'b1, pmosi = 1'b0, rise, aborted;
        forever begin
            @(negedge clk);
            rise = !pcs && cs_n[i];
            aborted = 1'b0;
            if (pcs && !cs_n[i]) begin
                st = cyc; nb = 0; sh = 0; unstable = 0;
            end
            if (!cs_n[i] && psclk && !sclk[i]) begin
                sh = {sh[30:0], mosi[i]};
                nb++;
                if (pmosi != mosi[i]) unstable++;
            end
            if (rise) begin
                k = -1;
                foreach (expq[j]) if (k < 0 && expq[j].inst == i) k = j;
                if (k < 0) begin
                    chk(1'b0, "unexpected_frame", sh, 0);
                end else begin
                    exp_t e = expq[k];
                    expq.delete(k);
                    if (abort_flag[i]) begin
                        aborted = 1'b1;
                        abort_flag[i] = 1'b0;
                        chk(nb < 32 && !frame_done[i], "abort_frame", nb, 32);
                    end else begin
                        chk(nb == 32 && sh == e.frame, "frame_bits", sh, e.frame);
                        chk(st == e.start, "frame_start_cycle", st, e.start);
                        chk(cyc - st == 64 * cdiv(i) && unstable == 0 && sclk[i],
                            "frame_timing", cyc - st, 64 * cdiv(i));
                    end
                end
            end
            if (rise || frame_done[i])
                chk(frame_done[i] == (rise && !aborted), "frame_done_pulse", frame_done[i], rise && !aborted);
            if (chan_err[i]) begin
                k = -1;
                foreach (errq[j]) if (k < 0 && errq[j].inst == i) k = j;
                if (k < 0) chk(1'b0, "unexpected_chan_err", cyc, 0);
                else begin
                    chk(cyc == errq[k].start, "chan_err_cycle", cyc, errq[k].start);
                    errq.delete(k);
                end
            end
            pcs = cs_n[i]; psclk = sclk[i]; pmosi = mosi[i];
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || errq.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(expq.size() == 0 && errq.size() == 0, "drain", expq.size() + errq.size(), 0);
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        reset = 1'b1;
        valid = 2'b00;
        eop   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            data[i] = '0;
            ch[i]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(ready[i] == 1'b0, "ready_in_reset", ready[i], 0);
            chk(cs_n[i] == 1'b1, "reset_cs_n", cs_n[i], 1);
            chk(sclk[i] == 1'b1, "reset_sclk", sclk[i], 1);
            chk(mosi[i] == 1'b0, "reset_mosi", mosi[i], 0);
            chk(frame_done[i] == 1'b0 && chan_err[i] == 1'b0, "reset_pulses", {frame_done[i], chan_err[i]}, 0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) chk(ready[i] == 1'b1, "ready_after_reset", ready[i], 1);

        // Immediate-update instance: extremes, mid-scale, bad channel, then random traffic
        send(0, 12'h800, 0, 1'b0, 0);
        send(0, 12'h000, 2, 1'b0, 0);
        send(0, 12'h7FF, 3, 1'b0, 0);
        send(0, 12'h123, 4, 1'b1, 0);
        send(0, 12'h456, 1, 1'b0, 2);
        for (int n = 0; n < 25; n++)
            send(0, 12'($urandom), $urandom_range(0, 5), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
        valid[0] = 1'b0;
        prev_hold[0] = 1'b0;
        drain();

        // Deferred-update instance: set ending in eop, bad channel with eop, back-to-back, random
        send(1, 12'($urandom), 0, 1'b0, 0);
        send(1, 12'($urandom), 1, 1'b1, 0);
        send(1, 12'($urandom), 6, 1'b1, 0);
        send(1, 12'($urandom), 2, 1'b0, 0);
        send(1, 12'($urandom), 3, 1'b0, 0);
        send(1, 12'($urandom), 0, 1'b0, 3);
        for (int n = 0; n < 12; n++)
            send(1, 12'($urandom), $urandom_range(0, 4), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        valid[1] = 1'b0;
        prev_hold[1] = 1'b0;
        drain();

        // Reset part-way through a frame aborts it without frame_done
        send(0, 12'hABC, 1, 1'b0, 1);
        repeat (29) @(negedge clk);
        abort_flag[0] = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk(cs_n[0] == 1'b1 && sclk[0] == 1'b1, "abort_lines_idle", {cs_n[0], sclk[0]}, 2'b11);
        chk(ready[0] == 1'b0, "abort_ready_low", ready[0], 0);
        reset = 1'b0;
        prev_hold = 2'b00;
        @(negedge clk);
        chk(ready[0] == 1'b1, "ready_after_abort", ready[0], 1);
        send(0, 12'h3C5, 2, 1'b0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
